// File: rtl/approx_mul_pipe.sv
// Three-stage pipelined unsigned multiplier with per-transaction exact/approximate mode,
// valid/ready flow control, a sideband tag and a saturating count of approximate results.
module approx_mul_pipe #(
  parameter int WIDTH       = 8,
  parameter int TRUNC       = 4,
  parameter int APPROX_COLS = 8,
  parameter int TAG_W       = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag,
  output logic [CNT_W-1:0]   cnt_approx,
  input  logic               cnt_clr
);

  localparam int P = 2 * WIDTH;
  localparam logic [P-1:0] ONES   = '1;
  localparam logic [P-1:0] H_MASK = ONES << APPROX_COLS;
  localparam logic [P-1:0] L_MASK = (ONES << TRUNC) & ~H_MASK;

  generate
    if (TRUNC < 0 || TRUNC > APPROX_COLS || APPROX_COLS > P - 1) begin : g_bad_params
      $error("approx_mul_pipe: illegal TRUNC/APPROX_COLS combination");
    end
  endgenerate

  // Handshake: a transfer happens on an edge where valid && ready. The whole pipe advances
  // together unless the output holds an unconsumed result; in_ready mirrors that advance.
  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [P-1:0]     s2_x;
  logic [P-1:0]     s2_y;
  logic             s2_mode;
  logic [TAG_W-1:0] s2_tag;

  logic [P-1:0] row;
  logic [P-1:0] lo_sum;
  logic [P-1:0] hi_sum;
  logic [P-1:0] h_sum;
  logic [P-1:0] rows_or;
  logic [P-1:0] x_next;
  logic [P-1:0] y_next;

  // Each shifted row holds one partial product per column, so OR-ing the rows gives the
  // per-column OR used by the approximate band.
  always_comb begin
    row     = '0;
    lo_sum  = '0;
    hi_sum  = '0;
    h_sum   = '0;
    rows_or = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row = s1_b[i] ? (P'(s1_a) << i) : '0;
      if (i < WIDTH / 2) lo_sum = lo_sum + row;
      else               hi_sum = hi_sum + row;
      h_sum   = h_sum + (row & H_MASK);
      rows_or = rows_or | row;
    end
    if (s1_mode) begin
      x_next = h_sum;
      y_next = rows_or & L_MASK;
    end else begin
      x_next = lo_sum;
      y_next = hi_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= 1'b0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_x      <= '0;
      s2_y      <= '0;
      s2_mode   <= 1'b0;
      s2_tag    <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_mode  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= in_mode;
        s1_tag  <= in_tag;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x    <= x_next;
        s2_y    <= y_next;
        s2_mode <= s1_mode;
        s2_tag  <= s1_tag;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_p    <= s2_x + s2_y;
        out_mode <= s2_mode;
        out_tag  <= s2_tag;
      end
    end
  end

  logic cnt_inc;
  assign cnt_inc = out_valid && out_ready && out_mode && (cnt_approx != {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      cnt_approx <= '0;
    end else if (cnt_inc) begin
      cnt_approx <= cnt_approx + 1'b1;
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// Bench for approx_mul_pipe: directed cases from the block description plus randomized
// traffic scored against a column-counting reference model.
module tb_approx_mul_pipe;

  localparam int WIDTH       = 8;
  localparam int TRUNC       = 4;
  localparam int APPROX_COLS = 8;
  localparam int TAG_W       = 4;
  localparam int CNT_W       = 16;
  localparam int SAT_W       = 2;
  localparam int P           = 2 * WIDTH;
  localparam int QW          = P + 1 + TAG_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [P-1:0]     out_p;
  logic             out_mode;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] cnt_approx;
  logic             cnt_clr;

  logic             s_in_ready;
  logic             s_out_valid;
  logic [P-1:0]     s_out_p;
  logic             s_out_mode;
  logic [TAG_W-1:0] s_out_tag;
  logic [SAT_W-1:0] s_cnt_approx;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  approx_mul_pipe #(.WIDTH(WIDTH), .TRUNC(TRUNC), .APPROX_COLS(APPROX_COLS),
                    .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .out_mode(out_mode), .out_tag(out_tag), .cnt_approx(cnt_approx), .cnt_clr(cnt_clr)
  );

  approx_mul_pipe #(.WIDTH(WIDTH), .TRUNC(TRUNC), .APPROX_COLS(APPROX_COLS),
                    .TAG_W(TAG_W), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_p(s_out_p),
    .out_mode(s_out_mode), .out_tag(s_out_tag), .cnt_approx(s_cnt_approx), .cnt_clr(cnt_clr)
  );

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_errors = 0;
  logic [QW-1:0]   exp_q[$];
  longint          exp_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: count the partial products landing in each column, then weight them.
  function automatic logic [P-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic mode);
    longint h;
    longint l;
    int     ones;
    int     i;
    if (!mode) return P'(longint'(a) * longint'(b));
    h = 0;
    l = 0;
    for (int c = 0; c < P; c++) begin
      ones = 0;
      for (int j = 0; j < WIDTH; j++) begin
        i = c - j;
        if (i >= 0 && i < WIDTH) begin
          if (a[j] && b[i]) ones++;
        end
      end
      if (c >= APPROX_COLS) h += longint'(ones) << c;
      else if (c >= TRUNC && ones > 0) l += longint'(1) << c;
    end
    return P'(h + l);
  endfunction

  function automatic longint sat(input longint v, input longint max);
    return (v > max) ? max : v;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with inputs driven; observes the handshakes of the coming edge.
  task automatic cycle(output bit acc, output bit del);
    logic [QW-1:0] e;
    #1;
    acc = rst_n && in_valid && in_ready;
    del = rst_n && out_valid && out_ready;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (del) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({out_p, out_mode, out_tag}), 64'(e));
        end
      end
      if (cnt_clr) exp_cnt = 0;
      else if (del && out_mode) exp_cnt++;
      if (acc) exp_q.push_back({ref_mul(in_a, in_b, in_mode), in_mode, in_tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bit a;
    bit d;
    cycle(a, d);
  endtask

  task automatic one_shot(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic mode,
                          input logic [TAG_W-1:0] tag, input logic [P-1:0] exp_p, input string name);
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_tag = tag; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(3));
    check({name, "_p"}, 64'(out_p), 64'(exp_p));
    check({name, "_mode"}, 64'(out_mode), 64'(mode));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    tick();
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] sa[8];
  logic [WIDTH-1:0] sb[8];
  logic [QW-1:0]    snap;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  int               k;
  int               got;
  int               wait_n;
  bit               acc;
  bit               del;
  bit               stall;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_tag = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_p", 64'(out_p), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_out_mode", 64'(out_mode), 64'(0));
    check("rst_cnt", 64'(cnt_approx), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Known products
    one_shot(8'hB5, 8'hDB, 1'b0, 4'hA, 16'h9AD7, "exact_b5db");
    one_shot(8'hFF, 8'hFF, 1'b1, 4'h3, 16'hF7F0, "approx_ffff");
    one_shot(8'hFF, 8'hFF, 1'b0, 4'h4, 16'hFE01, "exact_ffff");
    one_shot(8'h01, 8'h01, 1'b1, 4'h5, 16'h0000, "approx_trunc");
    one_shot(8'h01, 8'h01, 1'b0, 4'h6, 16'h0001, "exact_one");

    // Backpressure stream: 8 back-to-back, output stalled for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      sa[i] = WIDTH'($urandom);
      sb[i] = WIDTH'($urandom);
    end
    k = 0;
    got = 0;
    snap = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      stall = (cyc >= 4 && cyc < 9);
      if (cyc == 4) snap = {out_p, out_mode, out_tag};
      out_ready = !stall;
      in_valid = (k < 8);
      if (k < 8) begin
        in_a = sa[k]; in_b = sb[k]; in_mode = 1'(k & 1); in_tag = TAG_W'(k);
      end
      #1;
      if (stall) begin
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_out_valid_held", 64'(out_valid), 64'(1));
        check("bp_out_stable", 64'({out_p, out_mode, out_tag}), 64'(snap));
      end
      cycle(acc, del);
      if (acc) k++;
      if (del) got++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_all_sent", 64'(k), 64'(8));
    check("bp_all_received", 64'(got), 64'(8));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Counter: 3 approx + 2 exact, clear racing an increment, saturation on the narrow copy
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_cleared", 64'(cnt_approx), 64'(0));
    one_shot(8'h12, 8'h34, 1'b1, 4'h1, ref_mul(8'h12, 8'h34, 1'b1), "cnt_a0");
    one_shot(8'h56, 8'h78, 1'b0, 4'h2, 16'h2850, "cnt_e0");
    one_shot(8'h9A, 8'hBC, 1'b1, 4'h3, ref_mul(8'h9A, 8'hBC, 1'b1), "cnt_a1");
    one_shot(8'hDE, 8'hF0, 1'b0, 4'h4, 16'hD020, "cnt_e1");
    one_shot(8'h77, 8'h88, 1'b1, 4'h5, ref_mul(8'h77, 8'h88, 1'b1), "cnt_a2");
    check("cnt_three", 64'(cnt_approx), 64'(3));
    check("cnt_three_sat", 64'(s_cnt_approx), 64'(3));

    in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44; in_mode = 1'b1; in_tag = 4'h9;
    tick();
    in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 10) begin
      tick();
      wait_n++;
    end
    check("clr_race_out_valid", 64'(out_valid), 64'(1));
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("cnt_clr_wins", 64'(cnt_approx), 64'(0));
    check("cnt_clr_wins_sat", 64'(s_cnt_approx), 64'(0));

    for (int i = 0; i < 5; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      one_shot(ra, rb, 1'b1, TAG_W'(i), ref_mul(ra, rb, 1'b1), "sat_run");
    end
    check("cnt_five", 64'(cnt_approx), 64'(5));
    check("cnt_saturated", 64'(s_cnt_approx), 64'(3));

    // Reset with two transactions in flight
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'hC3; in_b = 8'h5A; in_mode = 1'b0; in_tag = 4'h5;
    tick();
    in_tag = 4'h6; in_mode = 1'b1;
    tick();
    rst_n = 1'b0; in_tag = 4'h7;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_cnt", 64'(cnt_approx), 64'(0));
    check("midrst_out_p", 64'(out_p), 64'(0));
    check("midrst_out_tag", 64'(out_tag), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_stale", 64'(out_valid), 64'(0));
    end

    // Randomized mixed-mode traffic with random backpressure
    in_valid = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a = WIDTH'($urandom);
        in_b = WIDTH'($urandom);
        in_mode = 1'($urandom_range(0, 1));
        in_tag = TAG_W'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr = ($urandom_range(0, 99) == 0);
      cycle(acc, del);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick();
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_cnt_model", 64'(cnt_approx), 64'(sat(exp_cnt, 65535)));
    check("rand_cnt_sat_model", 64'(s_cnt_approx), 64'(sat(exp_cnt, 3)));

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
